// File: rtl/pipe_mux_pkg.sv
// Shared constants, helpers and stage control record for the pipelined N:1 word mux.
package pipe_mux_pkg;

  localparam int SEL_BINARY = 0;
  localparam int SEL_ONEHOT = 1;
  localparam int MAX_NUM_IN = 16;

  // Ceiling log2 for elaboration-time sizing; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Control half of a pipeline stage; the data half is sized by the instantiating module.
  typedef struct packed {
    logic valid;
    logic err;
  } stage_flags_t;

endpackage

// File: rtl/pipe_mux_nto1_comb.sv
// Purely combinational N:1 word selector with binary or one-hot select and an illegal-select flag.
module mux_nto1_comb
  import pipe_mux_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int NUM_IN   = 4,
  parameter int SEL_MODE = SEL_BINARY,
  parameter int SEL_W    = (SEL_MODE == SEL_ONEHOT) ? NUM_IN : clog2(NUM_IN)
) (
  input  logic [NUM_IN*WIDTH-1:0] in_bus,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        word,
  output logic                    err
);

  generate
    if (SEL_MODE == SEL_ONEHOT) begin : g_onehot
      // Zero or multiple hot bits are illegal and force the word to zero.
      always_comb begin
        word = '0;
        err  = (sel == '0) || ((sel & (sel - 1'b1)) != '0);
        for (int k = 0; k < NUM_IN; k++) begin
          if (sel[k]) word = word | in_bus[k*WIDTH +: WIDTH];
        end
        if (err) word = '0;
      end
    end else begin : g_binary
      // Codes at or above NUM_IN match no word and stay flagged.
      always_comb begin
        word = '0;
        err  = 1'b1;
        for (int k = 0; k < NUM_IN; k++) begin
          if (sel == SEL_W'(k)) begin
            word = in_bus[k*WIDTH +: WIDTH];
            err  = 1'b0;
          end
        end
      end
    end
  endgenerate

endmodule

// File: rtl/pipe_mux_nto1.sv
// Registered N:1 word mux with a 1- or 2-stage output pipeline, valid tracking,
// stall/flush control and a registered illegal-select flag.
module pipe_mux_nto1
  import pipe_mux_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int NUM_IN      = 4,
  parameter int SEL_MODE    = SEL_BINARY,
  parameter int PIPE_STAGES = 1,
  parameter int SEL_W       = (SEL_MODE == SEL_ONEHOT) ? NUM_IN : clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_bus,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  input  logic                    stall,
  input  logic                    flush,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  output logic                    sel_err
);

  generate
    if (PIPE_STAGES < 1 || PIPE_STAGES > 2) begin : g_bad_stages
      $error("pipe_mux_nto1: PIPE_STAGES must be 1 or 2");
    end
    if (NUM_IN < 2 || NUM_IN > MAX_NUM_IN) begin : g_bad_num_in
      $error("pipe_mux_nto1: NUM_IN must be in 2..16");
    end
    if (WIDTH < 1) begin : g_bad_width
      $error("pipe_mux_nto1: WIDTH must be at least 1");
    end
    if (SEL_MODE != SEL_BINARY && SEL_MODE != SEL_ONEHOT) begin : g_bad_mode
      $error("pipe_mux_nto1: SEL_MODE must be 0 or 1");
    end
  endgenerate

  typedef struct packed {
    logic [WIDTH-1:0] data;
    stage_flags_t     flags;
  } stage_t;

  logic [WIDTH-1:0] mux_word;
  logic             mux_err;
  stage_t           next_stg;
  stage_t           stg [PIPE_STAGES];

  mux_nto1_comb #(
    .WIDTH    (WIDTH),
    .NUM_IN   (NUM_IN),
    .SEL_MODE (SEL_MODE),
    .SEL_W    (SEL_W)
  ) u_sel (
    .in_bus (in_bus),
    .sel    (sel),
    .word   (mux_word),
    .err    (mux_err)
  );

  // Handshake: in_valid qualifies in_bus/sel on every rising edge where rst_n=1,
  // flush=0 and stall=0. There is no ready; while stall is high the request is not
  // captured and the source must keep presenting it.
  always_comb begin
    next_stg             = '0;
    next_stg.data        = mux_word;
    next_stg.flags.valid = in_valid;
    next_stg.flags.err   = mux_err & in_valid;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      for (int i = 0; i < PIPE_STAGES; i++) stg[i] <= '0;
    end else if (!stall) begin
      stg[0] <= next_stg;
      for (int i = 1; i < PIPE_STAGES; i++) stg[i] <= stg[i-1];
    end
  end

  assign out_data  = stg[PIPE_STAGES-1].data;
  assign out_valid = stg[PIPE_STAGES-1].flags.valid;
  assign sel_err   = stg[PIPE_STAGES-1].flags.err;

endmodule

// File: tb/tb_pipe_mux_nto1.sv
// Directed plus short random bench for pipe_mux_nto1 across four configurations
// (binary/4, binary/3, one-hot/4, binary/4 with two stages).
module tb_pipe_mux_nto1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, stall, flush;
  logic [127:0] bus;
  logic [1:0]   sel0, sel1, sel3;
  logic [3:0]   sel2;
  logic         iv0, iv1, iv2, iv3;
  logic [31:0]  od0, od1, od2, od3;
  logic         ov0, ov1, ov2, ov3;
  logic         se0, se1, se2, se3;

  int n_checks = 0;
  int n_fail   = 0;

  // {err, data} expected at the output, in emission order, one queue per DUT.
  logic [32:0] q0[$];
  logic [32:0] q1[$];
  logic [32:0] q2[$];
  logic [32:0] q3[$];

  pipe_mux_nto1 #(.WIDTH(32), .NUM_IN(4), .SEL_MODE(0), .PIPE_STAGES(1)) u_bin4 (
    .clk(clk), .rst_n(rst_n), .in_bus(bus), .sel(sel0), .in_valid(iv0),
    .stall(stall), .flush(flush), .out_data(od0), .out_valid(ov0), .sel_err(se0));

  pipe_mux_nto1 #(.WIDTH(32), .NUM_IN(3), .SEL_MODE(0), .PIPE_STAGES(1)) u_bin3 (
    .clk(clk), .rst_n(rst_n), .in_bus(bus[95:0]), .sel(sel1), .in_valid(iv1),
    .stall(stall), .flush(flush), .out_data(od1), .out_valid(ov1), .sel_err(se1));

  pipe_mux_nto1 #(.WIDTH(32), .NUM_IN(4), .SEL_MODE(1), .PIPE_STAGES(1)) u_oh4 (
    .clk(clk), .rst_n(rst_n), .in_bus(bus), .sel(sel2), .in_valid(iv2),
    .stall(stall), .flush(flush), .out_data(od2), .out_valid(ov2), .sel_err(se2));

  pipe_mux_nto1 #(.WIDTH(32), .NUM_IN(4), .SEL_MODE(0), .PIPE_STAGES(2)) u_p2 (
    .clk(clk), .rst_n(rst_n), .in_bus(bus), .sel(sel3), .in_valid(iv3),
    .stall(stall), .flush(flush), .out_data(od3), .out_valid(ov3), .sel_err(se3));

  function automatic logic [32:0] model(input int n, input bit onehot,
                                        input logic [3:0] s, input logic [127:0] b);
    int idx;
    int cnt;
    if (!onehot) begin
      if (int'(s) < n) return {1'b0, b[int'(s)*32 +: 32]};
      return {1'b1, 32'h0};
    end
    idx = 0;
    cnt = 0;
    for (int k = 0; k < n; k++) begin
      if (s[k]) begin
        cnt++;
        idx = k;
      end
    end
    if (cnt == 1) return {1'b0, b[idx*32 +: 32]};
    return {1'b1, 32'h0};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input int id, input logic ov, input logic [31:0] od, input logic se);
    logic [32:0] e;
    bit          have;
    if (!ov) begin
      chk($sformatf("idle_sel_err%0d", id), se, 0);
      return;
    end
    have = 1'b0;
    e    = '0;
    case (id)
      0: if (q0.size() != 0) begin have = 1'b1; e = q0.pop_front(); end
      1: if (q1.size() != 0) begin have = 1'b1; e = q1.pop_front(); end
      2: if (q2.size() != 0) begin have = 1'b1; e = q2.pop_front(); end
      default: if (q3.size() != 0) begin have = 1'b1; e = q3.pop_front(); end
    endcase
    chk($sformatf("expected_output%0d", id), have, 1);
    if (have) begin
      chk($sformatf("sb_data%0d", id), od, e[31:0]);
      chk($sformatf("sb_err%0d", id), se, e[32]);
    end
  endtask

  // One clock: record what this edge should accept, then check after the edge.
  task automatic tick();
    bit adv;
    adv = !rst_n || flush || !stall;
    if (!rst_n || flush) begin
      q0.delete(); q1.delete(); q2.delete(); q3.delete();
    end else if (!stall) begin
      if (iv0) q0.push_back(model(4, 1'b0, {2'b00, sel0}, bus));
      if (iv1) q1.push_back(model(3, 1'b0, {2'b00, sel1}, bus));
      if (iv2) q2.push_back(model(4, 1'b1, sel2, bus));
      if (iv3) q3.push_back(model(4, 1'b0, {2'b00, sel3}, bus));
    end
    @(posedge clk);
    #1;
    if (adv) begin
      check_out(0, ov0, od0, se0);
      check_out(1, ov1, od1, se1);
      check_out(2, ov2, od2, se2);
      check_out(3, ov3, od3, se3);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ov0"}, ov0, 0); chk({tag, "_od0"}, od0, 0); chk({tag, "_se0"}, se0, 0);
    chk({tag, "_ov1"}, ov1, 0); chk({tag, "_od1"}, od1, 0); chk({tag, "_se1"}, se1, 0);
    chk({tag, "_ov2"}, ov2, 0); chk({tag, "_od2"}, od2, 0); chk({tag, "_se2"}, se2, 0);
    chk({tag, "_ov3"}, ov3, 0); chk({tag, "_od3"}, od3, 0); chk({tag, "_se3"}, se3, 0);
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    bus = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    sel0 = '0; sel1 = '0; sel2 = '0; sel3 = '0;
    iv0 = 1'b0; iv1 = 1'b0; iv2 = 1'b0; iv3 = 1'b0;

    // Reset state
    tick();
    tick();
    check_zero("reset");
    rst_n = 1'b1;
    tick();

    // Binary 4:1, one stage: back-to-back stream
    for (int i = 0; i < 4; i++) begin
      sel0 = 2'(i);
      iv0  = 1'b1;
      tick();
      chk("bin4_lat1_valid", ov0, 1);
    end
    iv0 = 1'b0;
    tick();
    chk("bin4_drained", ov0, 0);

    // Binary 3:1: out-of-range code, then a legal one
    sel1 = 2'd3; iv1 = 1'b1;
    tick();
    chk("bin3_err_flag", se1, 1);
    chk("bin3_err_data", od1, 0);
    sel1 = 2'd2;
    tick();
    chk("bin3_ok_flag", se1, 0);
    chk("bin3_ok_data", od1, 32'h33333333);
    iv1 = 1'b0;
    tick();

    // One-hot 4:1
    iv2 = 1'b1;
    sel2 = 4'b0100; tick(); chk("oh_word2", od2, 32'h33333333);
    sel2 = 4'b0110; tick(); chk("oh_two_hot", se2, 1);
    sel2 = 4'b0000; tick(); chk("oh_no_hot", se2, 1);
    sel2 = 4'b0001; tick(); chk("oh_word0", od2, 32'h11111111); chk("oh_word0_err", se2, 0);
    iv2 = 1'b0;
    tick();

    // Two stages: A, B, stall three cycles with C held, resume
    iv3 = 1'b1; sel3 = 2'd0;
    tick();
    chk("p2_lat_not_yet", ov3, 0);
    sel3 = 2'd1;
    tick();
    chk("p2_a_valid", ov3, 1);
    chk("p2_a_data", od3, 32'h11111111);
    stall = 1'b1; sel3 = 2'd2;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("p2_stall_valid", ov3, 1);
      chk("p2_stall_data", od3, 32'h11111111);
    end
    stall = 1'b0;
    tick();
    chk("p2_b_data", od3, 32'h22222222);
    iv3 = 1'b0;
    tick();
    chk("p2_c_data", od3, 32'h33333333);
    tick();
    chk("p2_empty", ov3, 0);

    // Flush together with stall, two words in flight, request in the same cycle
    iv3 = 1'b1; sel3 = 2'd3;
    tick();
    sel3 = 2'd0;
    tick();
    chk("p2_d_data", od3, 32'h44444444);
    flush = 1'b1; stall = 1'b1; sel3 = 2'd1;
    tick();
    chk("flush_valid", ov3, 0);
    flush = 1'b0; stall = 1'b0; iv3 = 1'b0;
    tick();
    chk("flush_no_leak1", ov3, 0);
    tick();
    chk("flush_no_leak2", ov3, 0);

    // Reset mid-stream, then latency after release
    iv0 = 1'b1; sel0 = 2'd1; iv3 = 1'b1; sel3 = 2'd2;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    check_zero("midrst");
    rst_n = 1'b1; sel0 = 2'd2; sel3 = 2'd3;
    tick();
    chk("rel_bin4_valid", ov0, 1);
    chk("rel_bin4_data", od0, 32'h33333333);
    chk("rel_p2_not_yet", ov3, 0);
    iv0 = 1'b0; iv3 = 1'b0;
    tick();
    chk("rel_p2_valid", ov3, 1);
    chk("rel_p2_data", od3, 32'h44444444);
    chk("rel_bin4_idle", ov0, 0);

    // Random traffic on all four instances
    for (int i = 0; i < 60; i++) begin
      bus   = {$urandom, $urandom, $urandom, $urandom};
      sel0  = 2'($urandom_range(0, 3));
      sel1  = 2'($urandom_range(0, 3));
      sel2  = 4'($urandom_range(0, 15));
      sel3  = 2'($urandom_range(0, 3));
      iv0   = 1'($urandom_range(0, 1));
      iv1   = 1'($urandom_range(0, 1));
      iv2   = 1'($urandom_range(0, 1));
      iv3   = 1'($urandom_range(0, 1));
      stall = ($urandom_range(0, 5) == 0);
      flush = ($urandom_range(0, 15) == 0);
      tick();
    end

    // Drain and confirm nothing was lost
    iv0 = 1'b0; iv1 = 1'b0; iv2 = 1'b0; iv3 = 1'b0;
    stall = 1'b0; flush = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("left_in_q0", q0.size(), 0);
    chk("left_in_q1", q1.size(), 0);
    chk("left_in_q2", q2.size(), 0);
    chk("left_in_q3", q3.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
